// File: rtl/fetch_ifid_stage.sv
// fetch_ifid_stage: program counter, instruction-memory address, and the IF/ID
// pipeline latch feeding decode. Handles stall (hold), redirect (branch/jump)
// and bubble insertion. Also keeps a count of instructions accepted into IF/ID.
`timescale 1ns/1ps
module fetch_ifid_stage #(
    parameter int unsigned                  ADDR_WIDTH  = 32,
    parameter int unsigned                  INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]        RESET_PC    = '0,
    parameter logic [INSTR_WIDTH-1:0]       NOP_WORD    = '0,
    parameter int unsigned                  CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    output logic [ADDR_WIDTH-1:0]  if_id_pc,
    output logic [INSTR_WIDTH-1:0] if_id_instr,
    output logic                   if_id_valid,
    output logic [CNT_WIDTH-1:0]   fetch_count
);

    logic [ADDR_WIDTH-1:0]  r_pc;
    logic [ADDR_WIDTH-1:0]  r_if_id_pc;
    logic [INSTR_WIDTH-1:0] r_if_id_instr;
    logic                   r_if_id_valid;
    logic [CNT_WIDTH-1:0]   r_fetch_count;
    logic [ADDR_WIDTH-1:0]  w_redirect_aligned;
    logic [ADDR_WIDTH-1:0]  w_pc_next_seq;

    // Redirect targets are word-aligned by clearing the low two bits
    always_comb begin
        w_redirect_aligned = redirect_pc & {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
        w_pc_next_seq      = r_pc + ADDR_WIDTH'(4);
    end

    // PC and IF/ID latch update: redirect beats stall, stall beats fetch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_if_id_pc    <= '0;
            r_if_id_instr <= NOP_WORD;
            r_if_id_valid <= 1'b0;
            r_fetch_count <= '0;
        end else if (redirect) begin
            r_pc          <= w_redirect_aligned;
            r_if_id_pc    <= '0;
            r_if_id_instr <= NOP_WORD;
            r_if_id_valid <= 1'b0;
        end else if (!stall) begin
            r_pc          <= w_pc_next_seq;
            r_if_id_pc    <= r_pc;
            r_if_id_instr <= imem_data;
            r_if_id_valid <= 1'b1;
            r_fetch_count <= r_fetch_count + CNT_WIDTH'(1);
        end
    end

    assign imem_addr   = r_pc;
    assign if_id_pc    = r_if_id_pc;
    assign if_id_instr = r_if_id_instr;
    assign if_id_valid = r_if_id_valid;
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Testbench for fetch_ifid_stage: directed scenarios plus a randomized run
// against a transaction-level model of the fetch pipeline.
`timescale 1ns/1ps
module tb_fetch_ifid_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic [15:0] fetch_count;

    // second instance: wrap-around PC start and a 2-bit counter
    logic        reset2;
    logic        stall2;
    logic        redirect2;
    logic [31:0] redirect_pc2;
    logic [31:0] imem_addr2;
    logic [31:0] imem_data2;
    logic [31:0] if_id_pc2;
    logic [31:0] if_id_instr2;
    logic        if_id_valid2;
    logic [1:0]  fetch_count2;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // reference model state
    logic [31:0] m_pc;
    logic [31:0] m_ifpc;
    logic [31:0] m_instr;
    logic        m_valid;
    int unsigned m_cnt;

    always #2 clk = ~clk;

    fetch_ifid_stage #(
        .ADDR_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(32'h0),
        .NOP_WORD(32'h0), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_data(imem_data),
        .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
        .fetch_count(fetch_count)
    );

    fetch_ifid_stage #(
        .ADDR_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(32'hFFFF_FFF8),
        .NOP_WORD(32'h0), .CNT_WIDTH(2)
    ) dut_wrap (
        .clk(clk), .reset(reset2), .stall(stall2), .redirect(redirect2),
        .redirect_pc(redirect_pc2), .imem_addr(imem_addr2), .imem_data(imem_data2),
        .if_id_pc(if_id_pc2), .if_id_instr(if_id_instr2), .if_id_valid(if_id_valid2),
        .fetch_count(fetch_count2)
    );

    // ROM contents: word i holds 0x1000 + i
    function automatic logic [31:0] rom(input logic [31:0] a);
        return 32'h1000 + (a >> 2);
    endfunction

    assign imem_data  = rom(imem_addr);
    assign imem_data2 = rom(imem_addr2);

    // model a reset: sequential fetch restarts at address 0
    task automatic model_reset();
        m_pc = 32'h0; m_ifpc = 32'h0; m_instr = 32'h0; m_valid = 1'b0; m_cnt = 0;
    endtask

    // drive one edge's inputs and advance the model by one fetch transaction
    task automatic step(input logic st, input logic rd, input logic [31:0] rpc);
        stall = st; redirect = rd; redirect_pc = rpc;
        if (rd) begin
            m_pc = (rpc / 4) * 4;
            m_ifpc = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
        end else if (!st) begin
            m_ifpc = m_pc; m_instr = rom(m_pc); m_valid = 1'b1;
            m_cnt = (m_cnt + 1) % 65536;
            m_pc = m_pc + 32'd4;
        end
        @(posedge clk); #1;
    endtask

    // synchronous-looking reset sequence aligned to posedge+1
    task automatic do_reset();
        stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        @(posedge clk); #1;
        m_ifpc = m_pc; m_instr = rom(m_pc); m_valid = 1'b1; m_cnt = 1; m_pc = 32'd4;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        #3;
        n_cmp++;
        if ({imem_addr, if_id_pc, if_id_instr, if_id_valid, fetch_count} !==
            {32'h0, 32'h0, 32'h0, 1'b0, 16'h0}) begin
            n_bad++;
            $display("FAIL reset_state: got pc=%h ifpc=%h instr=%h v=%b cnt=%0d, want all zero",
                     imem_addr, if_id_pc, if_id_instr, if_id_valid, fetch_count);
        end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_free_run();
        // reset released at 3 ns; first edge at 6 ns is the first fetch
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({if_id_pc, if_id_instr, if_id_valid, fetch_count} !==
                {32'(4*i), 32'h1000 + 32'(i), 1'b1, 16'(i+1)}) begin
                n_bad++;
                $display("FAIL free_run[%0d]: got ifpc=%h instr=%h v=%b cnt=%0d, want ifpc=%h instr=%h v=1 cnt=%0d",
                         i, if_id_pc, if_id_instr, if_id_valid, fetch_count, 4*i, 32'h1000+i, i+1);
            end
            if (i < 3) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_stall();
        do_reset();
        step(1'b0, 1'b0, 32'h0);           // pc now 8, IF/ID holds pc 4
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 32'h0);
            n_cmp++;
            if ({imem_addr, if_id_pc, if_id_instr, fetch_count} !==
                {32'h8, 32'h4, 32'h1001, 16'd2}) begin
                n_bad++;
                $display("FAIL stall_hold[%0d]: got pc=%h ifpc=%h instr=%h cnt=%0d, want pc=8 ifpc=4 instr=1001 cnt=2",
                         i, imem_addr, if_id_pc, if_id_instr, fetch_count);
            end
        end
        step(1'b0, 1'b0, 32'h0);
        n_cmp++;
        if ({if_id_pc, if_id_instr, if_id_valid, fetch_count} !== {32'h8, 32'h1002, 1'b1, 16'd3}) begin
            n_bad++;
            $display("FAIL stall_resume: got ifpc=%h instr=%h v=%b cnt=%0d, want ifpc=8 instr=1002 v=1 cnt=3",
                     if_id_pc, if_id_instr, if_id_valid, fetch_count);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);   // pc = 0x10
        step(1'b0, 1'b1, 32'h40);
        n_cmp++;
        if ({imem_addr, if_id_pc, if_id_instr, if_id_valid, fetch_count} !==
            {32'h40, 32'h0, 32'h0, 1'b0, 16'd4}) begin
            n_bad++;
            $display("FAIL redirect_bubble: got pc=%h ifpc=%h instr=%h v=%b cnt=%0d, want pc=40 ifpc=0 instr=0 v=0 cnt=4",
                     imem_addr, if_id_pc, if_id_instr, if_id_valid, fetch_count);
        end
        step(1'b0, 1'b0, 32'h0);
        n_cmp++;
        if ({if_id_pc, if_id_instr, if_id_valid, fetch_count} !== {32'h40, 32'h1010, 1'b1, 16'd5}) begin
            n_bad++;
            $display("FAIL redirect_target: got ifpc=%h instr=%h v=%b cnt=%0d, want ifpc=40 instr=1010 v=1 cnt=5",
                     if_id_pc, if_id_instr, if_id_valid, fetch_count);
        end
        step(1'b1, 1'b1, 32'h23);
        n_cmp++;
        if ({imem_addr, if_id_pc, if_id_instr, if_id_valid, fetch_count} !==
            {32'h20, 32'h0, 32'h0, 1'b0, 16'd5}) begin
            n_bad++;
            $display("FAIL redirect_over_stall: got pc=%h ifpc=%h instr=%h v=%b cnt=%0d, want pc=20 bubble cnt=5",
                     imem_addr, if_id_pc, if_id_instr, if_id_valid, fetch_count);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);
        stall = 1'b1;                      // reset lands mid-stall
        reset = 1'b1;
        #0.5;
        n_cmp++;
        if ({imem_addr, if_id_pc, if_id_instr, if_id_valid, fetch_count} !==
            {32'h0, 32'h0, 32'h0, 1'b0, 16'h0}) begin
            n_bad++;
            $display("FAIL async_reset: got pc=%h ifpc=%h instr=%h v=%b cnt=%0d, want all zero",
                     imem_addr, if_id_pc, if_id_instr, if_id_valid, fetch_count);
        end
        #0.5;
        reset = 1'b0;
        stall = 1'b0;
        model_reset();
        @(posedge clk); #1;
        n_cmp++;
        if ({imem_addr, if_id_pc, if_id_instr, if_id_valid, fetch_count} !==
            {32'h4, 32'h0, 32'h1000, 1'b1, 16'd1}) begin
            n_bad++;
            $display("FAIL async_reset_restart: got pc=%h ifpc=%h instr=%h v=%b cnt=%0d, want pc=4 ifpc=0 instr=1000 v=1 cnt=1",
                     imem_addr, if_id_pc, if_id_instr, if_id_valid, fetch_count);
        end
    endtask

    task automatic test_random();
        logic        st;
        logic        rd;
        logic [31:0] rpc;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            st  = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 7) == 0);
            rpc = $urandom;
            step(st, rd, rpc);
            n_cmp++;
            if ({imem_addr, if_id_pc, if_id_instr, if_id_valid, fetch_count} !==
                {m_pc, m_ifpc, m_instr, m_valid, 16'(m_cnt)}) begin
                n_bad++;
                $display("FAIL random[%0d] st=%b rd=%b: got pc=%h ifpc=%h instr=%h v=%b cnt=%0d, want pc=%h ifpc=%h instr=%h v=%b cnt=%0d",
                         i, st, rd, imem_addr, if_id_pc, if_id_instr, if_id_valid, fetch_count,
                         m_pc, m_ifpc, m_instr, m_valid, m_cnt);
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc;
        @(posedge clk); #1;
        reset2 = 1'b0;
        exp_pc = 32'hFFFF_FFF8;
        n_cmp++;
        if (imem_addr2 !== exp_pc) begin
            n_bad++;
            $display("FAIL wrap_start: got pc=%h, want %h", imem_addr2, exp_pc);
        end
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({imem_addr2, if_id_pc2, fetch_count2} !== {exp_pc + 32'd4, exp_pc, 2'(i % 4)}) begin
                n_bad++;
                $display("FAIL wrap[%0d]: got pc=%h ifpc=%h cnt=%0d, want pc=%h ifpc=%h cnt=%0d",
                         i, imem_addr2, if_id_pc2, fetch_count2, exp_pc + 32'd4, exp_pc, i % 4);
            end
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    initial begin
        reset2 = 1'b1; stall2 = 1'b0; redirect2 = 1'b0; redirect_pc2 = 32'h0;
        test_reset();
        test_free_run();
        test_stall();
        test_redirect();
        test_async_reset();
        test_random();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
